bmc_soft_pipe: RTL and testbench
================================

Name: bmc_soft_pipe

Overview:
- Parameterised, pipelined branch-metric unit for the Viterbi decoder.
- Takes N soft-decision received symbols per trellis step and emits metrics for all 2^N codeword hypotheses.
- Sits between the demapper/depuncture input and the ACS array; replaces fixed rate-1/2 hard-decision BMC cells.
- Valid/ready flow control; SW=1 reproduces Hamming-distance metrics exactly.

Parameters:
- N, 2, coded bits per trellis step (1/N code rate), 1..4
- SW, 3, soft symbol width; unsigned offset-binary, 0 = confident '0', 2^SW-1 = confident '1'
- MW, SW+$clog2(N+1), metric width (localparam, not overridable)
- PUNC_PERIOD, 4, puncture pattern period in trellis steps (used only with PUNCTURE_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input step valid
- in_ready  out  1  unit can accept a step
- in_sym  in  N*SW  soft symbols; symbol i at [i*SW +: SW]
- in_last  in  1  last step of frame
- out_valid  out  1  metrics valid
- out_ready  in  1  downstream accepts
- out_bm  out  (2^N)*MW  metric for hypothesis c at [c*MW +: MW]
- out_last  out  1  in_last delayed with its step
- punc_pattern  in  N*PUNC_PERIOD  keep mask; bit p*N+i = 1 keeps symbol i at phase p (PUNCTURE_EN only)

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_bm=0, out_last=0, internal valids=0, puncture phase=0. in_ready=1 after reset.
- Bit i of hypothesis index c corresponds to in_sym symbol i.
- Per-symbol distance: d0_i = s_i, d1_i = (2^SW-1) - s_i.
- out_bm[c] = sum over i of (c[i] ? d1_i : d0_i). Unsigned; MW bits; never overflows, so no saturation.
- Two-stage pipeline:
  - S1 registers d0/d1 per symbol.
  - S2 registers the sums.
  - Latency: exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
- Advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
  - Stage registers and valid flags load only when en=1.
  - With en=1 and no input accepted, the S1 valid flag clears.
- Stall: while out_valid=1 and out_ready=0, out_bm, out_last and out_valid hold stable; no step is lost or duplicated.
- Throughput: one step per cycle with out_ready held high.
- in_last travels with its step; out_last is asserted only together with out_valid.
- Data registers may load garbage when the corresponding valid flag is 0; out_bm is only meaningful with out_valid=1.
- Reset mid-stream: all in-flight steps are discarded; no out_valid after reset release until new input is accepted.

Optional Feature:
- Macro: BMC_SOFT_PIPE_PUNCTURE_EN.
- Defined:
  - punc_pattern port present.
  - Phase counter 0..PUNC_PERIOD-1 advances on each accepted step and wraps to 0.
  - Counter forced to 0 on the cycle after a step with in_last=1 is accepted.
  - A punctured symbol (mask bit 0) contributes 0 to every hypothesis: d0_i = d1_i = 0 in S1.
  - The mask is sampled with the step at acceptance.
- Undefined: no punc_pattern port, no phase counter, all symbols always contribute.

Test Plan:
- N=2, SW=3, in_sym {s1=7, s0=0}, out_ready=1 -> 2 cycles later out_bm c0..c3 = 7, 14, 0, 7; out_valid for exactly 1 cycle.
- N=2, SW=1, in_sym {s1=1, s0=0} -> out_bm c0..c3 = 1, 2, 0, 1 (Hamming distances).
- Stream of 8 back-to-back steps with out_ready=1 -> 8 consecutive out_valid cycles, metrics in order, in_last on step 8 -> out_last on output 8 only.
- Drop out_ready for 3 cycles with the pipeline full -> out_bm stable, in_ready=0, no loss; resume yields original order.
- PUNCTURE_EN, PUNC_PERIOD=2, pattern keeps all at phase 0 and punctures s1 at phase 1; steps {7,0} then {3,7} -> second step out_bm c0..c3 = 7, 0, 7, 0; after in_last the phase returns to 0.
- Assert rst_n low with 2 steps in flight -> out_valid=0 immediately; no stale output after release.

Source files
------------

// File: rtl/bmc_soft_pipe.sv
// Pipelined soft-decision branch-metric unit.
// Produces a metric for each of the 2^N codeword hypotheses from N soft
// symbols per trellis step. Stage 1 registers per-symbol distances, stage 2
// registers the per-hypothesis sums. Valid/ready flow control with a single
// advance enable shared by both stages.
// Optional feature: define BMC_SOFT_PIPE_PUNCTURE_EN to add the punc_pattern
// port and the puncture phase counter.
module bmc_soft_pipe #(
  parameter int unsigned N           = 2,
  parameter int unsigned SW          = 3,
  parameter int unsigned PUNC_PERIOD = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N*SW-1:0]                       in_sym,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(2**N)*(SW+$clog2(N+1))-1:0]    out_bm,
  output logic                                  out_last
`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
  ,
  input  logic [N*PUNC_PERIOD-1:0]              punc_pattern
`endif
);

  localparam int unsigned MW = SW + $clog2(N + 1);
  localparam int unsigned NH = 2 ** N;

  logic                   en;
  logic                   v1_q;
  logic                   last1_q;
  logic [N-1:0][SW-1:0]   d0_d, d1_d;
  logic [N-1:0][SW-1:0]   d0_q, d1_q;
  logic [NH-1:0][MW-1:0]  bm_d;

  // Whole pipeline advances unless the output is held by downstream.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
  localparam int unsigned PW = (PUNC_PERIOD > 1) ? $clog2(PUNC_PERIOD) : 1;

  logic [PW-1:0] phase_q;

  // Puncture phase: advances per accepted step, restarts after end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (in_valid && en) begin
      if (in_last || (phase_q == PW'(PUNC_PERIOD - 1))) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
    end
  end
`endif

  // Per-symbol distances to '0' and to '1'; (2^SW-1)-s is the bitwise inverse.
  always_comb begin
    d0_d = '0;
    d1_d = '0;
    for (int i = 0; i < N; i++) begin
      d0_d[i] = in_sym[i*SW +: SW];
      d1_d[i] = ~in_sym[i*SW +: SW];
`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
      // A punctured symbol carries no information, so it favours no hypothesis.
      if (!punc_pattern[int'(phase_q) * N + i]) begin
        d0_d[i] = '0;
        d1_d[i] = '0;
      end
`endif
    end
  end

  // Stage 1: distance registers and step valid/last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      last1_q <= in_last;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  // Hypothesis metrics: bit i of c selects the distance used for symbol i.
  always_comb begin
    bm_d = '0;
    for (int c = 0; c < NH; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c[i]) begin
          bm_d[c] = bm_d[c] + MW'(d1_q[i]);
        end else begin
          bm_d[c] = bm_d[c] + MW'(d0_q[i]);
        end
      end
    end
  end

  // Stage 2: output registers; out_last only ever qualifies a valid step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_bm    <= '0;
    end else if (en) begin
      out_valid <= v1_q;
      out_last  <= v1_q && last1_q;
      out_bm    <= bm_d;
    end
  end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed self-checking bench for bmc_soft_pipe: one N=2/SW=3 instance for
// the main sequence and one N=2/SW=1 instance for the Hamming-distance case.
// The puncture sequence runs only when BMC_SOFT_PIPE_PUNCTURE_EN is defined.
module tb_bmc_soft_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [5:0]  in_sym;
  logic [19:0] out_bm;

  logic        h_valid, h_ready_in, h_last, h_out_valid, h_out_ready, h_out_last;
  logic [1:0]  h_sym;
  logic [11:0] h_bm;

  int checks   = 0;
  int failures = 0;

`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
  logic [3:0] punc;
  logic [7:0] h_punc;
`endif

  always #5 clk = ~clk;

  bmc_soft_pipe #(
    .N (2),
    .SW(3)
`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
    ,
    .PUNC_PERIOD(2)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sym   (in_sym),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bm   (out_bm),
    .out_last (out_last)
`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
    ,
    .punc_pattern(punc)
`endif
  );

  bmc_soft_pipe #(
    .N (2),
    .SW(1)
  ) dut_h (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (h_valid),
    .in_ready (h_ready_in),
    .in_sym   (h_sym),
    .in_last  (h_last),
    .out_valid(h_out_valid),
    .out_ready(h_out_ready),
    .out_bm   (h_bm),
    .out_last (h_out_last)
`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
    ,
    .punc_pattern(h_punc)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference metrics for N=2, SW=3: |s - 7*bit| summed over both symbols.
  function automatic logic [19:0] model3(input logic [5:0] sym);
    logic [19:0] r;
    int          acc;
    int          s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      acc = 0;
      for (int i = 0; i < 2; i++) begin
        s = int'(sym[i*3 +: 3]);
        acc += ((c >> i) & 1) ? (7 - s) : s;
      end
      r[c*5 +: 5] = 5'(acc);
    end
    return r;
  endfunction

  logic [5:0] stream [8] = '{6'o00, 6'o77, 6'o12, 6'o34, 6'o56, 6'o70, 6'o25, 6'o43};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_sym = '0; in_last = 1'b0; out_ready = 1'b1;
    h_valid = 1'b0; h_sym = '0; h_last = 1'b0; h_out_ready = 1'b1;
`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
    punc = 4'b0111;  // phase 0 keeps both, phase 1 drops s1
    h_punc = 8'hff;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_bm", 32'(out_bm), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single step {s1=7, s0=0}, and the SW=1 Hamming case {s1=1, s0=0}.
    in_valid = 1'b1; in_sym = 6'o70;
    h_valid = 1'b1; h_sym = 2'b10;
    tick();
    in_valid = 1'b0; h_valid = 1'b0;
    check_eq("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check_eq("lat2_valid", 32'(out_valid), 32'd1);
    check_eq("lat2_bm", 32'(out_bm), 32'({5'd7, 5'd0, 5'd14, 5'd7}));
    check_eq("ham_valid", 32'(h_out_valid), 32'd1);
    check_eq("ham_bm", 32'(h_bm), 32'({3'd1, 3'd0, 3'd2, 3'd1}));
    tick();
    check_eq("single_pulse", 32'(out_valid), 32'd0);

    // Back-to-back stream of 8 steps, last flag on step 8.
    for (int t = 0; t < 11; t++) begin
      if (t >= 2 && t < 10) begin
        check_eq($sformatf("stream_valid%0d", t - 2), 32'(out_valid), 32'd1);
        check_eq($sformatf("stream_bm%0d", t - 2), 32'(out_bm), 32'(model3(stream[t-2])));
        check_eq($sformatf("stream_last%0d", t - 2), 32'(out_last), 32'(t == 9));
      end else if (t == 10) begin
        check_eq("stream_drained", 32'(out_valid), 32'd0);
      end
      if (t < 8) begin
        in_valid = 1'b1; in_sym = stream[t]; in_last = (t == 7);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      tick();
    end

    // Stall with the pipeline full: A at output, B in stage 1, C waiting.
    in_valid = 1'b1; in_sym = 6'o15; in_last = 1'b0;  // A
    tick();
    in_sym = 6'o62;                                    // B
    tick();
    out_ready = 1'b0;
    in_sym = 6'o47; in_last = 1'b1;                    // C, ends the frame
    #1;
    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("stall_valid%0d", k), 32'(out_valid), 32'd1);
      check_eq($sformatf("stall_bm%0d", k), 32'(out_bm), 32'(model3(6'o15)));
      check_eq($sformatf("stall_ready%0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("resume_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check_eq("resume_b_bm", 32'(out_bm), 32'(model3(6'o62)));
    check_eq("resume_b_valid", 32'(out_valid), 32'd1);
    tick();
    check_eq("resume_c_bm", 32'(out_bm), 32'(model3(6'o47)));
    check_eq("resume_c_last", 32'(out_last), 32'd1);
    tick();
    check_eq("resume_drained", 32'(out_valid), 32'd0);

`ifdef BMC_SOFT_PIPE_PUNCTURE_EN
    // Phase 0 {7,0}, phase 1 {3,7} with s1 dropped and last, then phase 0 again.
    in_valid = 1'b1; in_sym = 6'o70; in_last = 1'b0;
    tick();
    in_sym = 6'o37; in_last = 1'b1;
    tick();
    check_eq("punc_p0_bm", 32'(out_bm), 32'({5'd7, 5'd0, 5'd14, 5'd7}));
    in_sym = 6'o70; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    check_eq("punc_p1_bm", 32'(out_bm), 32'({5'd0, 5'd7, 5'd0, 5'd7}));
    check_eq("punc_p1_last", 32'(out_last), 32'd1);
    tick();
    check_eq("punc_phase_restart_bm", 32'(out_bm), 32'({5'd7, 5'd0, 5'd14, 5'd7}));
    tick();
`endif

    // Reset with two steps in flight.
    in_valid = 1'b1; in_sym = 6'o11;
    tick();
    in_sym = 6'o22;
    tick();
    in_valid = 1'b0;
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("post_rst_quiet%0d", k), 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
